// File: rtl/ads1299_pkg.sv
// Shared constants for the ADS1299 RDATAC frame reader: word geometry, status header and FSM encoding.
package ads1299_pkg;
    localparam int         ADS_WORD_BITS  = 24;
    localparam logic [3:0] ADS_STATUS_HDR = 4'hC;
    localparam int         ADS_MAX_CH     = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CSS   = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_CSH   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator (CPOL=0): CLK_DIV cycles high, CLK_DIV low; first rise on the first enabled edge.
// rise_tick/fall_tick are high in the cycle whose closing edge moves sclk; no backpressure.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          at_last;

    assign at_last   = (cnt == CNT_LAST);
    assign rise_tick = en && at_last && !sclk;
    assign fall_tick = en && at_last && sclk;

    // Parking the counter at its last value makes the first enabled cycle raise SCLK.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            sclk <= 1'b0;
            cnt  <= CNT_LAST;
        end else if (at_last) begin
            sclk <= ~sclk;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/ads1299_frame_reader.sv
// Reads one ADS1299 RDATAC frame per DRDY fall and forwards the selected channel as a sign-extended x/x_valid strobe.
// x_valid fires T_CSH+1 cycles after the last SCLK fall; DRDY falls while busy are counted as overruns and dropped.
module ads1299_frame_reader
    import ads1299_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int N_CH    = 8,
    parameter int Q_out   = 32,
    parameter int T_CSS   = 8,
    parameter int T_CSH   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       ch_sel,
    input  logic             drdy_n,
    input  logic             spi_miso,
    output logic             spi_sclk,
    output logic             spi_cs_n,
    output logic             spi_mosi,
    output logic [Q_out-1:0] x,
    output logic             x_valid,
    output logic [23:0]      status,
    output logic             frame_err,
    output logic [15:0]      overrun_cnt
);
    localparam logic [7:0] CSS_LAST  = 8'(T_CSS - 1);
    localparam logic [7:0] CSH_LAST  = 8'(T_CSH - 1);
    localparam logic [4:0] BIT_LAST  = 5'(ADS_WORD_BITS - 1);
    localparam logic [3:0] WORD_LAST = 4'(N_CH);

    logic [2:0]               drdy_sync;
    logic [1:0]               miso_sync;
    logic                     drdy_fall;
    logic                     miso_s;
    logic [2:0]               state;
    logic [7:0]               timer;
    logic [4:0]               bit_cnt;
    logic [3:0]               word_idx;
    logic [2:0]               ch_lat;
    logic                     ch_ok;
    logic [ADS_WORD_BITS-2:0] shreg;
    logic [ADS_WORD_BITS-1:0] word;
    logic [ADS_WORD_BITS-1:0] status_hold;
    logic [ADS_WORD_BITS-1:0] sample_hold;
    logic                     sclk_en;
    logic                     rise_tick;
    logic                     fall_tick;

    assign drdy_fall = drdy_sync[2] && !drdy_sync[1];
    assign miso_s    = miso_sync[1];
    assign word      = {shreg, miso_s};
    assign ch_ok     = ({1'b0, ch_lat} < WORD_LAST);
    assign spi_mosi  = 1'b0;
    // Enabled in the last CSS cycle so the first rise lands exactly T_CSS cycles after CS_n falls.
    assign sclk_en   = (state == ST_SHIFT) || ((state == ST_CSS) && (timer == CSS_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            drdy_sync <= 3'b111;
            miso_sync <= 2'b00;
        end else begin
            drdy_sync <= {drdy_sync[1:0], drdy_n};
            miso_sync <= {miso_sync[0], spi_miso};
        end
    end

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk       (clk),
        .reset     (reset),
        .en        (sclk_en),
        .sclk      (spi_sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            spi_cs_n    <= 1'b1;
            timer       <= '0;
            bit_cnt     <= '0;
            word_idx    <= '0;
            ch_lat      <= '0;
            shreg       <= '0;
            status_hold <= '0;
            sample_hold <= '0;
            x           <= '0;
            x_valid     <= 1'b0;
            status      <= '0;
            frame_err   <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            x_valid <= 1'b0;
            if (drdy_fall && (state != ST_IDLE) && (overrun_cnt != 16'hFFFF))
                overrun_cnt <= overrun_cnt + 16'd1;

            case (state)
                ST_IDLE: begin
                    if (drdy_fall) begin
                        state    <= ST_CSS;
                        spi_cs_n <= 1'b0;
                        ch_lat   <= ch_sel;
                        timer    <= '0;
                        bit_cnt  <= '0;
                        word_idx <= '0;
                    end
                end
                ST_CSS: begin
                    if (rise_tick) state <= ST_SHIFT;
                    else           timer <= timer + 8'd1;
                end
                ST_SHIFT: begin
                    if (fall_tick) begin
                        shreg <= word[ADS_WORD_BITS-2:0];
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt  <= '0;
                            word_idx <= word_idx + 4'd1;
                            if (word_idx == 4'd0)
                                status_hold <= word;
                            if (word_idx == {1'b0, ch_lat} + 4'd1)
                                sample_hold <= word;
                            if (word_idx == WORD_LAST) begin
                                state <= ST_CSH;
                                timer <= '0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                ST_CSH: begin
                    if (timer == CSH_LAST) begin
                        spi_cs_n <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                ST_DONE: begin
                    status <= status_hold;
                    if (status_hold[23:20] != ADS_STATUS_HDR)
                        frame_err <= 1'b1;
                    if (ch_ok) begin
                        x       <= Q_out'($signed(sample_hold));
                        x_valid <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
